// File: rtl/range_ctrl_pkg.sv
// Shared types and key indices for the range_ctrl sequencing controller.
package range_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        SHOW   = 2'd3
    } state_t;

    localparam int unsigned KEY_INC = 0;
    localparam int unsigned KEY_DEC = 1;
    localparam int unsigned KEY_CLR = 2;
    localparam int unsigned KEY_GO  = 3;

endpackage

// File: rtl/range_ctrl_key_debounce.sv
// One pushbutton: 2-flop synchroniser, debounce counter, press-edge pulse
// and optional hold/auto-repeat events.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000,
    parameter bit          REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    logic [1:0]    sync;
    logic          pressed_s;
    logic          db;
    logic [DW-1:0] db_cnt;
    logic          db_flip;
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_lim;
    logic          rep_phase;
    logic          rep_fire;
    logic          evt;

    assign pressed_s = ~sync[1];
    assign db_flip   = (pressed_s != db) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
    assign rep_lim   = rep_phase ? RW'(REPEAT_CYCLES - 1) : RW'(HOLD_CYCLES - 1);
    // A debounced release in the same cycle suppresses any pending repeat.
    assign rep_fire  = REPEAT_EN && db && !db_flip && (rep_cnt == rep_lim);
    assign press     = evt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync      <= '1;
            db        <= 1'b0;
            db_cnt    <= '0;
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
            evt       <= 1'b0;
        end else begin
            sync <= {sync[0], key_n};

            if (pressed_s != db) begin
                db_cnt <= db_flip ? '0 : db_cnt + 1'b1;
            end else begin
                db_cnt <= '0;
            end

            if (db_flip) begin
                db <= pressed_s;
            end

            evt <= (db_flip && pressed_s) || rep_fire;

            if (!db || db_flip) begin
                rep_cnt   <= '0;
                rep_phase <= 1'b0;
            end else if (rep_cnt == rep_lim) begin
                rep_cnt   <= '0;
                rep_phase <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/range_ctrl.sv
// Launch/step controller for the Collatz range datapath: conditions KEY[3:0],
// launches a run from SW, then steps a read offset through the result RAM.
module range_ctrl
    import range_ctrl_pkg::*;
#(
    parameter int unsigned RAM_WORDS       = 256,
    parameter int unsigned RAM_ADDR_BITS   = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               key_n,
    input  logic [9:0]               sw,
    output logic                     range_go,
    output logic [31:0]              range_start,
    input  logic                     range_done,
    output logic [RAM_ADDR_BITS-1:0] range_n,
    output logic [11:0]              disp_value,
    output logic                     busy,
    output logic                     valid
);

    localparam logic [RAM_ADDR_BITS-1:0] OFF_MAX = RAM_ADDR_BITS'(RAM_WORDS - 1);

    logic [3:0]               key_evt;
    state_t                   state, state_d;
    logic [9:0]               sw_q, sw_d;
    logic [RAM_ADDR_BITS-1:0] offset, offset_d;

    for (genvar g = 0; g < 4; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES),
            .REPEAT_EN      (g == KEY_INC || g == KEY_DEC)
        ) u_key (
            .clk  (clk),
            .reset(reset),
            .key_n(key_n[g]),
            .press(key_evt[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            sw_q   <= '0;
            offset <= '0;
        end else begin
            state  <= state_d;
            sw_q   <= sw_d;
            offset <= offset_d;
        end
    end

    always_comb begin
        state_d  = state;
        sw_d     = sw_q;
        offset_d = offset;
        case (state)
            IDLE: begin
                if (key_evt[KEY_GO]) begin
                    sw_d     = sw;
                    offset_d = '0;
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: state_d = RUN;
            RUN: begin
                if (range_done) state_d = SHOW;
            end
            SHOW: begin
                // Only the highest-priority key acts: GO > CLR > INC > DEC.
                if (key_evt[KEY_GO]) begin
                    sw_d     = sw;
                    offset_d = '0;
                    state_d  = LAUNCH;
                end else if (key_evt[KEY_CLR]) begin
                    offset_d = '0;
                end else if (key_evt[KEY_INC]) begin
                    if (offset != OFF_MAX) offset_d = offset + 1'b1;
                end else if (key_evt[KEY_DEC]) begin
                    if (offset != '0) offset_d = offset - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign range_go    = (state == LAUNCH);
    assign busy        = (state == LAUNCH) || (state == RUN);
    assign valid       = (state == SHOW);
    assign range_start = {22'b0, sw_q};
    assign range_n     = offset;
    assign disp_value  = range_start[11:0] + 12'(offset);

endmodule

// File: doc/range_ctrl.md
# range_ctrl

Sequencing controller for the Collatz `range` datapath on the DE1-SoC lab top level. It conditions the four raw pushbuttons with synchronisers, debounce and auto-repeat. It launches a range run from the switch value, waits for completion, and then lets the user step a read index through the result RAM. It sits between the board I/O (`KEY`, `SW`) and `range`, and replaces the direct `go = !KEY[3]` wiring.

## Interface
- `RAM_WORDS`, 256, number of results produced per run.
- `RAM_ADDR_BITS`, 8, width of the read index.
- `DEBOUNCE_CYCLES`, 500000, stable cycles required to accept a key change (10 ms at 50 MHz).
- `HOLD_CYCLES`, 25000000, hold time before auto-repeat starts (0.5 s).
- `REPEAT_CYCLES`, 5000000, auto-repeat period (0.1 s).

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: 50 MHz system clock (`CLOCK_50`).
- `reset` in 1: synchronous, active-high.
- `key_n` in 4: raw pushbuttons, active-low, asynchronous. Bit 0 is the rightmost button.
- `sw` in 10: raw slide switches, giving the start value.
- `range_go` out 1: one-cycle launch pulse to `range`.
- `range_start` out 32: start value for `range`, equal to `{22'b0, sw}` latched at launch.
- `range_done` in 1: completion from `range`, level or pulse.
- `range_n` out `RAM_ADDR_BITS`: result read index (the offset).
- `disp_value` out 12: `range_start[11:0] + offset`, mod 4096, used for the HEX display.
- `busy` out 1: high while in LAUNCH or RUN.
- `valid` out 1: high in SHOW, meaning results are readable.

## Operation
- Key path, per key: a 2-flop synchroniser feeds a debouncer.
  - The debounced state changes only after the synchronised input differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any bounce restarts the count.
  - A press event is a 1-cycle pulse on the released-to-pressed transition.
- Auto-repeat applies to `KEY[0]` and `KEY[1]` only.
  - While held, an extra event fires `HOLD_CYCLES` after the press event.
  - Further events follow every `REPEAT_CYCLES`.
  - Release stops repeat immediately.
- FSM states:
  - IDLE: no results yet; `valid`=0.
    - `KEY[3]` event: latch `sw` into `range_start`, set offset to 0, go to LAUNCH.
    - Other keys are ignored.
  - LAUNCH (1 cycle): `range_go`=1, then go to RUN.
  - RUN: wait for `range_done`=1, then go to SHOW.
    - All key events are ignored and dropped, not queued.
  - SHOW: `valid`=1.
    - `KEY[3]` event: relaunch (same action as from IDLE).
    - `KEY[2]`: offset set to 0.
    - `KEY[0]`: offset+1, saturating at `RAM_WORDS-1`.
    - `KEY[1]`: offset-1, saturating at 0.
- Simultaneous events in one cycle: only the highest-priority key takes effect, in the order `KEY[3]` > `KEY[2]` > `KEY[0]` > `KEY[1]`.
- `range_done` is sampled only in RUN. A `range_done` still high in IDLE, LAUNCH or SHOW has no effect.
- `disp_value` is a 12-bit wrap-around sum: for example, `sw`=0x3FF with offset 0xFF gives 0x4FE. `range_start[31:12]` (the upper bits) are always 0.

## Timing
- Reset values:
  - `range_go`=0, `range_start`=0, `range_n`=0, `disp_value`=0, `busy`=0, `valid`=0.
  - FSM in IDLE.
  - All debounced keys released; all counters 0.
- Key latency: a raw edge produces an event `2 + DEBOUNCE_CYCLES` cycles later (±1).
- Launch timeline, with the `KEY[3]` event in cycle E:
  - `range_start` is updated at E+1 with `sw` as sampled at E.
  - `range_go`=1 during E+1 only.
  - RUN from E+2; `range_done` is first sampled at E+2.
  - If `range_done` is seen at cycle D, SHOW and `valid`=1 start at D+1.
- `range_start` is stable from LAUNCH until the next LAUNCH.
- Offset updates are visible on `range_n` and `disp_value` one cycle after the event.
- Reset asserted mid-RUN: the controller returns to IDLE next cycle and `range_go` stays 0. `range` is reset by its own means; the controller does not reset it.

## Structure
- `range_ctrl_pkg` contains:
  - the `state_t` enum (IDLE, LAUNCH, RUN, SHOW);
  - localparams `KEY_INC`=0, `KEY_DEC`=1, `KEY_CLR`=2, `KEY_GO`=3.
- Sub-module `key_debounce` holds the synchroniser, the debounce counter, edge detection and optional auto-repeat (enable parameter). It is instantiated 4× using a generate loop.
- Top-level `range_ctrl` holds the FSM, offset register and adder.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=16, `REPEAT_CYCLES`=4, `RAM_WORDS`=16, `RAM_ADDR_BITS`=4.
- Reset: all outputs 0. A `range_done` pulse while in IDLE leaves `valid`=0.
- Bounce: `KEY[3]` toggled low/high every 2 cycles for 20 cycles, then held low → exactly one `range_go` pulse, about 6 cycles after the stable low.
- Launch: `sw`=0x2A5, press `KEY[3]` → `range_start`=0x2A5, a 1-cycle `range_go`, `busy`=1. `range_done` 10 cycles later → `valid`=1 next cycle, `disp_value`=0x2A5.
- Step/saturate: in SHOW, press `KEY[1]` → `range_n`=0. Hold `KEY[0]` for 100 cycles → `range_n` steps 1, 2, … and stops at 15. Press `KEY[2]` → 0.
- Simultaneous and busy: `KEY[0]`+`KEY[2]` in the same cycle → `range_n`=0. `KEY[0]` pressed during RUN → `range_n` unchanged after `range_done`.
- Reset mid-RUN: assert `reset` two cycles after `range_go` → IDLE and `busy`=0 next cycle. A later `range_done` → `valid` stays 0.
